// File: rtl/video_counters.sv
// ============================================================================
// Module   : video_counters
// Purpose  : Video-matrix counter (vc/vcbase), row counter (rc), line index
//            (vmli) and idle/display state, advanced once per CPU cycle.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module video_counters #(
  parameter logic [6:0] VCBASE_CLR_CYCLE = 7'd1,
  parameter logic [6:0] VC_LOAD_CYCLE    = 7'd13,
  parameter logic [6:0] G_FIRST_CYCLE    = 7'd15,
  parameter logic [6:0] G_LAST_CYCLE     = 7'd54,
  parameter logic [6:0] RC_UPDATE_CYCLE  = 7'd57
) (
  input  logic       clk_dot4x,
  input  logic       rst,
  input  logic       cycle_stb,
  input  logic [6:0] cycle_num,
  input  logic [8:0] raster_line,
  input  logic       badline,
  output logic [9:0] vc,
  output logic [9:0] vcbase,
  output logic [2:0] rc,
  output logic [5:0] vmli,
  output logic       idle
);

  logic [9:0] r_vc;
  logic [9:0] r_vcbase;
  logic [2:0] r_rc;
  logic [5:0] r_vmli;
  logic       r_idle;

  logic w_g_window;
  logic w_display_now;
  logic w_display_after_rc;

  assign w_g_window    = (cycle_num >= G_FIRST_CYCLE) && (cycle_num <= G_LAST_CYCLE);
  assign w_display_now = !r_idle || badline;
  // State left by the row-end check: a badline always forces display, while
  // finishing row 7 without one drops into idle.
  assign w_display_after_rc = badline || (!r_idle && (r_rc != 3'd7));

  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst) begin
      r_vc     <= 10'd0;
      r_vcbase <= 10'd0;
      r_rc     <= 3'd0;
      r_vmli   <= 6'd0;
      r_idle   <= 1'b1;
    end else if (cycle_stb) begin
      if (badline)
        r_idle <= 1'b0;

      if ((raster_line == 9'd0) && (cycle_num == VCBASE_CLR_CYCLE))
        r_vcbase <= 10'd0;

      if (cycle_num == VC_LOAD_CYCLE) begin
        r_vc   <= r_vcbase;
        r_vmli <= 6'd0;
        if (badline)
          r_rc <= 3'd0;
      end

      if (w_g_window && w_display_now) begin
        r_vc   <= r_vc + 10'd1;
        r_vmli <= r_vmli + 6'd1;
      end

      if (cycle_num == RC_UPDATE_CYCLE) begin
        if (r_rc == 3'd7) begin
          r_vcbase <= r_vc;
          if (!badline)
            r_idle <= 1'b1;
        end
        if (w_display_after_rc)
          r_rc <= r_rc + 3'd1;
      end
    end
  end

  assign vc     = r_vc;
  assign vcbase = r_vcbase;
  assign rc     = r_rc;
  assign vmli   = r_vmli;
  assign idle   = r_idle;

endmodule

`default_nettype wire
